// File: rtl/aes_dec_pkg.sv
// ---------------------------------------------------------------------------
// aes_dec_pkg
// Definitions shared by the AES decryptor arbiter and its round-robin
// selector.
//   decState_e      : FSM state encoding (IDLE / BUSY / RELEASE)
//   DEFAULT_TIMEOUT : default number of BUSY cycles waited for DecRy
//   CNT_W           : width of the BUSY cycle counter
//   DATA_W          : AES block / key width
//   portOneHot()    : converts a 1-bit port index into a 2-bit one-hot vector
// ---------------------------------------------------------------------------
package aes_dec_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } decState_e;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int CNT_W           = 9;
  localparam int DATA_W          = 128;

  function automatic logic [1:0] portOneHot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin selector (purely combinational).
//   Req0, Req1 : request levels
//   Ptr        : index of the requester served last
//   Grant      : index of the winning requester (valid only when Valid=1)
//   Valid      : at least one request is present
// With both requests high the requester not served last wins; a single
// request wins regardless of Ptr.
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic Req0,
  input  logic Req1,
  input  logic Ptr,
  output logic Grant,
  output logic Valid
);

  assign Valid = Req0 | Req1;
  assign Grant = (Req0 & Req1) ? ~Ptr : Req1;

endmodule

// File: rtl/aes_dec_arbiter.sv
// ---------------------------------------------------------------------------
// aes_dec_arbiter
// Shares one AES decryptor between two requesters. A job is accepted in IDLE,
// the decryptor is enabled during BUSY until it reports ready or the cycle
// budget runs out, and RELEASE drops the enable for one cycle so the
// decryptor restarts before the next job.
//   Clk, Rst        : clock, asynchronous active-low reset
//   Req0/Req1       : level-sensitive job requests
//   CT0/CT1,Key0/1  : ciphertext and key of each requester
//   Ack0/1          : one-cycle pulse, job accepted
//   Done0/1         : one-cycle pulse, PT0/1 updated with the result
//   Err0/1          : one-cycle pulse, job timed out (PT unchanged)
//   PT0/PT1         : plaintext, held until the port's next Done
//   DecEn,DecCT,DecKey : enable and latched operands to the decryptor
//   DecRy, DecPT    : ready and plaintext from the decryptor
//   Busy            : high whenever the FSM is not in IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module aes_dec_arbiter
  import aes_dec_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [DATA_W-1:0] CT0,
  input  logic [DATA_W-1:0] CT1,
  input  logic [DATA_W-1:0] Key0,
  input  logic [DATA_W-1:0] Key1,
  output logic              Ack0,
  output logic              Ack1,
  output logic              Done0,
  output logic              Done1,
  output logic              Err0,
  output logic              Err1,
  output logic [DATA_W-1:0] PT0,
  output logic [DATA_W-1:0] PT1,
  output logic              DecEn,
  output logic [DATA_W-1:0] DecCT,
  output logic [DATA_W-1:0] DecKey,
  input  logic              DecRy,
  input  logic [DATA_W-1:0] DecPT,
  output logic              Busy
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  decState_e         stateReg,  stateNext;
  logic [CNT_W-1:0]  cntReg,    cntNext;
  logic [CNT_W-1:0]  cntInc;
  logic              ptrReg,    ptrNext;
  logic              grantReg,  grantNext;
  logic              decEnReg,  decEnNext;
  logic              busyReg,   busyNext;
  logic [1:0]        ackReg,    ackNext;
  logic [1:0]        doneReg,   doneNext;
  logic [1:0]        errReg,    errNext;
  logic [DATA_W-1:0] decCtReg,  decCtNext;
  logic [DATA_W-1:0] decKeyReg, decKeyNext;
  logic [DATA_W-1:0] pt0Reg,    pt0Next;
  logic [DATA_W-1:0] pt1Reg,    pt1Next;

  logic arbGrant;
  logic arbValid;

  rr_arb2 uArb (
    .Req0  (Req0),
    .Req1  (Req1),
    .Ptr   (ptrReg),
    .Grant (arbGrant),
    .Valid (arbValid)
  );

  assign cntInc = cntReg + CNT_W'(1);

  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    ptrNext    = ptrReg;
    grantNext  = grantReg;
    decEnNext  = decEnReg;
    ackNext    = 2'b00;
    doneNext   = 2'b00;
    errNext    = 2'b00;
    decCtNext  = decCtReg;
    decKeyNext = decKeyReg;
    pt0Next    = pt0Reg;
    pt1Next    = pt1Reg;

    case (stateReg)
      IDLE: begin
        if (arbValid) begin
          stateNext  = BUSY;
          cntNext    = '0;
          ptrNext    = arbGrant;
          grantNext  = arbGrant;
          decEnNext  = 1'b1;
          ackNext    = portOneHot(arbGrant);
          decCtNext  = arbGrant ? CT1 : CT0;
          decKeyNext = arbGrant ? Key1 : Key0;
        end
      end

      BUSY: begin
        cntNext = cntInc;
        // Ready is tested first so a result arriving on the last allowed
        // cycle is reported as Done rather than Err.
        if (DecRy) begin
          stateNext = RELEASE;
          decEnNext = 1'b0;
          doneNext  = portOneHot(grantReg);
          if (grantReg) begin
            pt1Next = DecPT;
          end else begin
            pt0Next = DecPT;
          end
        end else if (cntInc == TIMEOUT_CNT) begin
          stateNext = RELEASE;
          decEnNext = 1'b0;
          errNext   = portOneHot(grantReg);
        end
      end

      RELEASE: begin
        stateNext = IDLE;
        decEnNext = 1'b0;
      end

      default: begin
        stateNext = IDLE;
        decEnNext = 1'b0;
      end
    endcase

    busyNext = (stateNext != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      stateReg  <= IDLE;
      cntReg    <= '0;
      ptrReg    <= 1'b1;   // requester 0 wins the first contention
      grantReg  <= 1'b0;
      decEnReg  <= 1'b0;
      busyReg   <= 1'b0;
      ackReg    <= 2'b00;
      doneReg   <= 2'b00;
      errReg    <= 2'b00;
      decCtReg  <= '0;
      decKeyReg <= '0;
      pt0Reg    <= '0;
      pt1Reg    <= '0;
    end else begin
      stateReg  <= stateNext;
      cntReg    <= cntNext;
      ptrReg    <= ptrNext;
      grantReg  <= grantNext;
      decEnReg  <= decEnNext;
      busyReg   <= busyNext;
      ackReg    <= ackNext;
      doneReg   <= doneNext;
      errReg    <= errNext;
      decCtReg  <= decCtNext;
      decKeyReg <= decKeyNext;
      pt0Reg    <= pt0Next;
      pt1Reg    <= pt1Next;
    end
  end

  assign Ack0   = ackReg[0];
  assign Ack1   = ackReg[1];
  assign Done0  = doneReg[0];
  assign Done1  = doneReg[1];
  assign Err0   = errReg[0];
  assign Err1   = errReg[1];
  assign PT0    = pt0Reg;
  assign PT1    = pt1Reg;
  assign DecEn  = decEnReg;
  assign DecCT  = decCtReg;
  assign DecKey = decKeyReg;
  assign Busy   = busyReg;

endmodule

// File: tb/tb_aes_dec_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aes_dec_arbiter
// Directed and randomized jobs against aes_dec_arbiter (TIMEOUT=10). A stub
// decryptor raises DecRy in the L-th consecutive enabled cycle (L chosen per
// job); the expected outcome of a job is computed from the job-level rules:
// Done at Ack+L when L<=TIMEOUT, else Err at Ack+TIMEOUT.
// ---------------------------------------------------------------------------
module tb_aes_dec_arbiter;

  localparam int TO = 10;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         Req0 = 1'b0, Req1 = 1'b0;
  logic [127:0] CT0 = '0, CT1 = '0, Key0 = '0, Key1 = '0;
  logic         Ack0, Ack1, Done0, Done1, Err0, Err1;
  logic [127:0] PT0, PT1;
  logic         DecEn;
  logic [127:0] DecCT, DecKey;
  logic         DecRy = 1'b0;
  logic [127:0] DecPT = '0;
  logic         Busy;

  int total = 0;
  int bad   = 0;
  int stubLat = 1;
  int enCnt = 0;
  bit ptrModel = 1'b1;
  logic [127:0] ptModel [2];

  aes_dec_arbiter #(.TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0(Req0), .Req1(Req1),
    .CT0(CT0), .CT1(CT1), .Key0(Key0), .Key1(Key1),
    .Ack0(Ack0), .Ack1(Ack1), .Done0(Done0), .Done1(Done1),
    .Err0(Err0), .Err1(Err1), .PT0(PT0), .PT1(PT1),
    .DecEn(DecEn), .DecCT(DecCT), .DecKey(DecKey),
    .DecRy(DecRy), .DecPT(DecPT), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Decryptor behaviour: the FIPS-197 vector decrypts to its known plaintext,
  // anything else to a simple keyed scramble.
  function automatic logic [127:0] decModel(input logic [127:0] ct, input logic [127:0] key);
    if (ct == FIPS_CT && key == FIPS_KEY) return FIPS_PT;
    return ct ^ {key[63:0], key[127:64]};
  endfunction

  // Stub decryptor: ready in the stubLat-th consecutive enabled cycle,
  // garbage on DecPT whenever not ready.
  always @(negedge Clk) begin
    if (DecEn) enCnt = enCnt + 1;
    else       enCnt = 0;
    DecRy = DecEn && (enCnt == stubLat);
    DecPT = DecRy ? decModel(DecCT, DecKey) : rand128();
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One job from IDLE: drive requests, expect the round-robin winner's Ack,
  // then Done or Err at the cycle given by the latency rule, then IDLE.
  task automatic runJob(input bit r0, input bit r1, input int lat,
                        input bit hold, input bit fips, output bit wOut);
    bit w;
    int ev;
    bit ok;
    logic [127:0] ctW, keyW;
    logic [1:0] oh;
    Req0 = r0; Req1 = r1;
    CT0 = rand128(); Key0 = rand128(); CT1 = rand128(); Key1 = rand128();
    if (fips) begin CT0 = FIPS_CT; Key0 = FIPS_KEY; end
    stubLat = lat;
    w = (r0 && r1) ? !ptrModel : r1;
    ptrModel = w;
    wOut = w;
    ctW  = w ? CT1 : CT0;
    keyW = w ? Key1 : Key0;
    oh   = w ? 2'b10 : 2'b01;
    ok   = (lat <= TO);
    ev   = ok ? lat : TO;

    @(posedge Clk); #1;
    check("ack", 128'({Ack1, Ack0}), 128'(oh));
    check("decen_on", 128'(DecEn), 128'(1));
    check("busy_on", 128'(Busy), 128'(1));
    check("decct", DecCT, ctW);
    check("deckey", DecKey, keyW);
    check("quiet_at_ack", 128'({Done1, Done0, Err1, Err0}), 128'(0));
    if (!hold) begin Req0 = 1'b0; Req1 = 1'b0; end

    for (int i = 1; i < ev; i++) begin
      CT0 = rand128(); CT1 = rand128(); Key0 = rand128(); Key1 = rand128();
      @(posedge Clk); #1;
      check("busy_quiet", 128'({Ack1, Ack0, Done1, Done0, Err1, Err0}), 128'(0));
      check("busy_decen", 128'(DecEn), 128'(1));
      check("busy_ct_stable", DecCT, ctW);
      check("busy_key_stable", DecKey, keyW);
    end

    if (ok) ptModel[w] = decModel(ctW, keyW);
    @(posedge Clk); #1;
    check("done", 128'({Done1, Done0}), ok ? 128'(oh) : 128'(0));
    check("err", 128'({Err1, Err0}), ok ? 128'(0) : 128'(oh));
    check("pt0", PT0, ptModel[0]);
    check("pt1", PT1, ptModel[1]);
    check("release_decen", 128'(DecEn), 128'(0));
    check("release_busy", 128'(Busy), 128'(1));
    check("release_ack", 128'({Ack1, Ack0}), 128'(0));

    @(posedge Clk); #1;
    check("idle_busy", 128'(Busy), 128'(0));
    check("idle_decen", 128'(DecEn), 128'(0));
    check("idle_quiet", 128'({Ack1, Ack0, Done1, Done0, Err1, Err0}), 128'(0));
    $display("job port=%0d lat=%0d result=%s", w, lat, ok ? "done" : "timeout");
  endtask

  initial begin
    bit w;
    bit expOrder [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    ptModel[0] = '0;
    ptModel[1] = '0;

    // Reset state
    #3;
    check("rst_decen", 128'(DecEn), 128'(0));
    check("rst_busy", 128'(Busy), 128'(0));
    check("rst_pulses", 128'({Ack1, Ack0, Done1, Done0, Err1, Err0}), 128'(0));
    check("rst_pt0", PT0, 128'(0));
    check("rst_pt1", PT1, 128'(0));
    check("rst_decct", DecCT, 128'(0));
    check("rst_deckey", DecKey, 128'(0));
    @(negedge Clk); @(negedge Clk);
    Rst = 1'b1;

    // Single job with the FIPS-197 vector
    runJob(1'b1, 1'b0, 3, 1'b0, 1'b1, w);
    check("fips_pt0", PT0, FIPS_PT);

    // Contention from reset: both requests held, order 0,1,0,1
    @(negedge Clk);
    Rst = 1'b0; Req0 = 1'b1; Req1 = 1'b1;
    ptrModel = 1'b1; ptModel[0] = '0; ptModel[1] = '0;
    @(negedge Clk);
    Rst = 1'b1;
    for (int j = 0; j < 4; j++) begin
      runJob(1'b1, 1'b1, 1 + j, 1'b1, 1'b0, w);
      check("rr_order", 128'(w), 128'(expOrder[j]));
    end

    // Timeout on port 1, then completion on the timeout cycle (tie)
    runJob(1'b0, 1'b1, 99, 1'b0, 1'b0, w);
    runJob(1'b1, 1'b0, TO, 1'b0, 1'b0, w);

    // Held request on port 1 across Done1
    runJob(1'b0, 1'b1, 2, 1'b1, 1'b0, w);
    runJob(1'b0, 1'b1, 2, 1'b0, 1'b0, w);

    // Reset in the middle of a job
    Req0 = 1'b0; Req1 = 1'b1; stubLat = 99;
    @(posedge Clk); #1;
    check("mid_ack", 128'({Ack1, Ack0}), 128'(2'b10));
    Req1 = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #2;
    Rst = 1'b0;
    #1;
    check("mid_rst_decen", 128'(DecEn), 128'(0));
    check("mid_rst_busy", 128'(Busy), 128'(0));
    check("mid_rst_decct", DecCT, 128'(0));
    check("mid_rst_pt1", PT1, 128'(0));
    ptrModel = 1'b1; ptModel[0] = '0; ptModel[1] = '0;
    @(posedge Clk); #1;
    check("mid_rst_quiet", 128'({Done1, Done0, Err1, Err0}), 128'(0));
    @(negedge Clk);
    Rst = 1'b1;
    runJob(1'b1, 1'b1, 2, 1'b0, 1'b0, w);
    check("after_rst_winner", 128'(w), 128'(0));

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      int pat;
      pat = $urandom_range(1, 3);
      runJob(pat[0], pat[1], $urandom_range(1, 12), 1'($urandom_range(0, 1)), 1'b0, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_dec_arbiter.md
AES_DEC_ARBITER -- requirements
Module: aes_dec_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT, default 255, giving the maximum number of BUSY cycles waited for decryptor Ry.
REQ-002 The module SHALL have port Clk, input, 1: the single clock; all state updates on rising edge.
REQ-003 The module SHALL have port Rst, input, 1: asynchronous, active-low reset.
REQ-004 The module SHALL have ports Req0/Req1, input, 1 each: job request, level-sensitive.
REQ-005 The module SHALL have ports CT0/CT1, input, 128 each: requester ciphertext.
REQ-006 The module SHALL have ports Key0/Key1, input, 128 each: requester key.
REQ-007 The module SHALL have ports Ack0/Ack1, output, 1 each: one-cycle pulse when the job is accepted.
REQ-008 The module SHALL have ports Done0/Done1, output, 1 each: one-cycle pulse when the result is valid.
REQ-009 The module SHALL have ports Err0/Err1, output, 1 each: one-cycle pulse on timeout.
REQ-010 The module SHALL have ports PT0/PT1, output, 128 each: plaintext, held until that port's next Done.
REQ-011 The module SHALL have port DecEn, output, 1: enable to the AES_Decryptor.
REQ-012 The module SHALL have ports DecCT/DecKey, output, 128 each: latched CT and key of the granted job.
REQ-013 The module SHALL have port DecRy, input, 1: ready from the AES_Decryptor.
REQ-014 The module SHALL have port DecPT, input, 128: plaintext from the AES_Decryptor.
REQ-015 The module SHALL have port Busy, output, 1: high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, BUSY, RELEASE; all outputs SHALL be registered.
REQ-017 In IDLE with any Req high at edge N, the module SHALL latch the winner's CT/Key into DecCT/DecKey, go to BUSY, and drive Ack(winner)=1 and DecEn=1 during cycle N+1.
REQ-018 When both Req are high in IDLE, the grant SHALL go to the requester not served last (round-robin); the last-served pointer SHALL reset to 1, so requester 0 wins first.
REQ-019 When only one Req is high, that requester SHALL be granted regardless of the pointer; the pointer SHALL update on every grant.
REQ-020 In BUSY, DecEn SHALL stay 1 and DecCT/DecKey SHALL stay constant; a change on CTx/Keyx after Ack SHALL be ignored.
REQ-021 In BUSY, on the first edge with DecRy=1, the module SHALL copy DecPT into PT(granted), pulse Done(granted) for the next cycle and go to RELEASE.
REQ-022 A 9-bit cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-023 When the counter reaches TIMEOUT with DecRy=0, the module SHALL pulse Err(granted), leave PT unchanged and go to RELEASE.
REQ-024 When DecRy=1 and the counter reaches TIMEOUT on the same edge, completion SHALL win: Done, not Err.
REQ-025 In RELEASE, DecEn SHALL be 0 for exactly one cycle so the decryptor restarts, then the state SHALL go to IDLE.
REQ-026 A Req still high after Ack, or asserted during BUSY/RELEASE, SHALL be treated as a new job evaluated in IDLE.
REQ-027 The minimum job-to-job spacing SHALL be 3 cycles (IDLE, BUSY>=1, RELEASE).
REQ-028 Ack, Done and Err SHALL never be high for both ports in the same cycle; Done and Err SHALL be mutually exclusive.

Reset
REQ-029 On Rst=0 the module SHALL asynchronously enter IDLE, with no edge required.
REQ-030 On reset, DecEn, Ack*, Done* and Err* SHALL be 0 and Busy SHALL be 0.
REQ-031 On reset, PT0/PT1/DecCT/DecKey SHALL be 0, the counter SHALL be 0 and the pointer SHALL be 1.
REQ-032 A reset during BUSY SHALL abort the job with no Done or Err pulse.

Structure
REQ-033 State encoding and the default TIMEOUT constant SHALL live in shared package aes_dec_pkg.
REQ-034 The two-requester round-robin selector SHALL be a sub-module rr_arb2 (inputs Req0/Req1, pointer; output grant index and valid).
REQ-035 aes_dec_arbiter SHALL instantiate rr_arb2 and connect to AES_Decryptor with DecEn->En, DecCT->CT, DecKey->Key, Ry->DecRy, PT->DecPT.

Verification
REQ-036 Single job: Req0=1 with CT0=69c4e0d86a7b0430d8cdb78070b4c55a, Key0=000102030405060708090a0b0c0d0e0f, plus the real decryptor -> Ack0 next cycle, then Done0 with PT0=00112233445566778899aabbccddeeff.
REQ-037 Contention: Req0 and Req1 both high from reset -> order 0, 1, 0, 1 and never two Acks in one cycle.
REQ-038 Timeout: stub DecRy=0 with TIMEOUT=10 -> Err1 exactly 10 BUSY cycles after Ack1, DecEn low one cycle, PT1 unchanged.
REQ-039 Tie: DecRy rising on the TIMEOUT cycle -> Done pulses, Err stays 0.
REQ-040 Reset mid-job: Rst=0 in BUSY -> DecEn=0 and Busy=0 immediately, no Done/Err, and the next grant goes to port 0.
REQ-041 Held request: Req1 kept high across Done1 -> second job accepted after RELEASE, with DecEn low exactly one cycle between jobs.
